// File: rtl/alu_writeback.sv
// alu_writeback: result writeback sequencer behind the ALU.
// Checks each accepted operation against its condition code and the NZCV
// register. It then issues one or two register-file writes, routes r15
// writes to the PC strobe, and owns the architectural flags.
//
// Optional feature: define WB_LONGMUL_EN to enable the second (RdLo) write
// for UMULL/SMULL. Without it, rd_lo and result2 are ignored.
//
// Ports:
//   clk, reset (async, active-low)
//   valid_in / ready_out       operation handshake
//   alu_op, result, result2    ALU outputs (result2 = RdLo for long multiply)
//   alu_flags, cond, s_bit     flag source, condition field, flag-update enable
//   no_wb                      suppress register write (compare/test ops)
//   rd, rd_lo                  destination addresses
//   we3, wa3, wd3              register-file write port (registered)
//   pc_wr                      PC write strobe, target on wd3 (registered)
//   flags                      architectural {N,Z,C,V}
//   cond_ex                    condition-pass result of the last accepted op
//   done                       one-cycle retire pulse
module alu_writeback #(
    parameter int unsigned RF_AW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [3:0]       alu_op,
    input  logic [31:0]      result,
    input  logic [31:0]      result2,
    input  logic [3:0]       alu_flags,
    input  logic [3:0]       cond,
    input  logic             s_bit,
    input  logic             no_wb,
    input  logic [RF_AW-1:0] rd,
    input  logic [RF_AW-1:0] rd_lo,
    output logic             we3,
    output logic [RF_AW-1:0] wa3,
    output logic [31:0]      wd3,
    output logic             pc_wr,
    output logic [3:0]       flags,
    output logic             cond_ex,
    output logic             done
);

    localparam logic [RF_AW-1:0] PC_ADDR = RF_AW'(15);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR1  = 2'd1,
        WR2  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic             accept_c;
    logic             cond_pass_c;
    logic [3:0]       flags_q, flags_d;
    logic             cond_ex_q, cond_ex_d;
    logic [RF_AW-1:0] rd_q, rd_d;
    logic [31:0]      result_q, result_d;
    logic             we3_q, we3_d;
    logic             pc_wr_q, pc_wr_d;
    logic [RF_AW-1:0] wa3_q, wa3_d;
    logic [31:0]      wd3_q, wd3_d;
    logic             done_q, done_d;

`ifdef WB_LONGMUL_EN
    logic             long_q, long_d;
    logic [RF_AW-1:0] rd_lo_q, rd_lo_d;
    logic [31:0]      result2_q, result2_d;
`else
    logic             unused_longmul_c;
    assign unused_longmul_c = ^{rd_lo, result2};
`endif

    assign ready_out = (state_q == IDLE);
    assign accept_c  = valid_in & ready_out;

    // Condition evaluated against the flags held before this op updates them
    always_comb begin
        cond_pass_c = 1'b1;
        unique case (cond)
            4'b0000: cond_pass_c = flags_q[2];
            4'b0001: cond_pass_c = ~flags_q[2];
            4'b0010: cond_pass_c = flags_q[1];
            4'b0011: cond_pass_c = ~flags_q[1];
            4'b0100: cond_pass_c = flags_q[3];
            4'b0101: cond_pass_c = ~flags_q[3];
            4'b0110: cond_pass_c = flags_q[0];
            4'b0111: cond_pass_c = ~flags_q[0];
            4'b1000: cond_pass_c = flags_q[1] & ~flags_q[2];
            4'b1001: cond_pass_c = ~flags_q[1] | flags_q[2];
            4'b1010: cond_pass_c = (flags_q[3] == flags_q[0]);
            4'b1011: cond_pass_c = (flags_q[3] != flags_q[0]);
            4'b1100: cond_pass_c = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_pass_c = flags_q[2] | (flags_q[3] != flags_q[0]);
            default: cond_pass_c = 1'b1;
        endcase
    end

    // Arithmetic and FP ops write all of NZCV; logic/move ops keep C and V
    always_comb begin
        flags_d = flags_q;
        if (accept_c && cond_pass_c && s_bit) begin
            casez (alu_op)
                4'b000?, 4'b10??:                   flags_d = alu_flags;
                4'b0010, 4'b0011, 4'b01??, 4'b1100: flags_d = {alu_flags[3:2], flags_q[1:0]};
                default:                            flags_d = flags_q;
            endcase
        end
    end

    // Operand capture on accept
    always_comb begin
        cond_ex_d = accept_c ? cond_pass_c : cond_ex_q;
        rd_d      = accept_c ? rd : rd_q;
        result_d  = accept_c ? result : result_q;
`ifdef WB_LONGMUL_EN
        long_d    = accept_c ? ((alu_op == 4'b0101) || (alu_op == 4'b0110)) : long_q;
        rd_lo_d   = accept_c ? rd_lo : rd_lo_q;
        result2_d = accept_c ? result2 : result2_q;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = (!cond_pass_c || no_wb) ? FIN : WR1;
                end
            end
`ifdef WB_LONGMUL_EN
            WR1:     state_d = long_q ? WR2 : IDLE;
`else
            WR1:     state_d = IDLE;
`endif
            WR2:     state_d = IDLE;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: computed for the state being entered so outputs are registered
    always_comb begin
        we3_d   = 1'b0;
        pc_wr_d = 1'b0;
        wa3_d   = '0;
        wd3_d   = '0;
        done_d  = 1'b0;
        unique case (state_d)
            WR1: begin
                wa3_d   = rd_d;
                wd3_d   = result_d;
                pc_wr_d = (rd_d == PC_ADDR);
                we3_d   = (rd_d != PC_ADDR);
`ifdef WB_LONGMUL_EN
                done_d  = ~long_d;
`else
                done_d  = 1'b1;
`endif
            end
            WR2: begin
`ifdef WB_LONGMUL_EN
                wa3_d   = rd_lo_d;
                wd3_d   = result2_d;
                pc_wr_d = (rd_lo_d == PC_ADDR);
                we3_d   = (rd_lo_d != PC_ADDR);
                done_d  = 1'b1;
`endif
            end
            FIN:     done_d = 1'b1;
            default: done_d = 1'b0;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
            rd_q      <= '0;
            result_q  <= '0;
            we3_q     <= 1'b0;
            pc_wr_q   <= 1'b0;
            wa3_q     <= '0;
            wd3_q     <= '0;
            done_q    <= 1'b0;
`ifdef WB_LONGMUL_EN
            long_q    <= 1'b0;
            rd_lo_q   <= '0;
            result2_q <= '0;
`endif
        end else begin
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            we3_q     <= we3_d;
            pc_wr_q   <= pc_wr_d;
            wa3_q     <= wa3_d;
            wd3_q     <= wd3_d;
            done_q    <= done_d;
`ifdef WB_LONGMUL_EN
            long_q    <= long_d;
            rd_lo_q   <= rd_lo_d;
            result2_q <= result2_d;
`endif
        end
    end

    assign we3     = we3_q;
    assign pc_wr   = pc_wr_q;
    assign wa3     = wa3_q;
    assign wd3     = wd3_q;
    assign done    = done_q;
    assign flags   = flags_q;
    assign cond_ex = cond_ex_q;

endmodule
